crc_stream: RTL and testbench
=============================

Name: crc_stream

Overview:
Parametrised bit-serial CRC engine for the SPI/SD link. It replaces the fixed 32-bit-input CRC7 block with a streaming word interface. One instance, CRC_W=7, covers command frames. A second instance, CRC_W=16 with POLY=16'h1021, covers 512-byte data blocks. Check mode is built in: feeding a message plus its appended CRC leaves a zero residue, which is flagged on crc_ok.

Parameters:
CRC_W, 7, CRC register width (7 for SD commands, 16 for SD data)
POLY, 7'h09, generator polynomial without the implicit x^CRC_W term (x^7+x^3+1)
INIT, 0, CRC register value loaded on start
DATA_W, 8, bits per input word, shifted MSB first
CNT_W, $clog2(DATA_W), bit-counter width (derived; do not override)

Ports:
clk  in  1  system clock; all logic on rising edge only
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
start  in  1  begin new message; sampled only in IDLE
clear  in  1  synchronous abort to IDLE from any state; discards the CRC
in_data  in  DATA_W  message word
in_valid  in  1  in_data valid
in_last  in  1  marks final word of message, qualified by in_valid
in_ready  out  1  engine can accept a word this cycle
busy  out  1  high in every state except IDLE
crc_out  out  CRC_W  current CRC register
crc_ok  out  1  crc_out==0; meaningful when done is high
done  out  1  one-cycle pulse, final CRC valid

Behaviour:
- Reset state: IDLE.
- Reset values: crc register = INIT; in_ready, busy, done and crc_ok = 0; shift register and bit counter = 0.
- States: IDLE, ACCEPT, SHIFT, DONE.
- IDLE:
  - start=1 loads crc=INIT and moves to ACCEPT.
  - start=0 holds the state; crc_out keeps the last result.
- ACCEPT:
  - in_ready=1 (combinational from state only).
  - in_valid=1 latches in_data into the shift register, latches in_last, sets bit counter = DATA_W-1, and moves to SHIFT.
  - in_valid=0 waits with no timeout.
- SHIFT, one bit per cycle:
  - fb = crc[CRC_W-1] ^ sh[DATA_W-1]
  - crc <= {crc[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0)
  - sh <= sh<<1; counter decrements.
  - At counter==0: move to DONE if the latched last=1, else return to ACCEPT.
- DONE: done=1 and crc_ok=(crc==0) for exactly one cycle, then IDLE.
- Outputs hold: crc_out holds the final value after DONE until the next accepted start.
- Latency with in_valid held high:
  - Each word costs DATA_W+1 cycles (1 accept + DATA_W shift).
  - For a start sampled at cycle 0 and an N-word message, done is high in cycle 1+N*(DATA_W+1).
- Handshake rules:
  - Words are accepted only on in_valid & in_ready.
  - in_last outside a handshake is ignored.
  - in_data may change freely while in_ready=0.
- Simultaneous events:
  - clear has priority over start and over the handshake.
  - start while busy is ignored, with no restart.
  - A start in the DONE cycle is ignored; start is re-sampled in IDLE.
- Async reset mid-message returns immediately to IDLE with reset values; no done pulse is produced.
- Arithmetic is modulo-2 only; no carries. A width-1 message (N=1) is legal.
- SD command framing ({crc7,1'b1}) is done by the caller, not inside this block.

Decomposition:
- Shared package sd_pkg holds:
  - CRC7_POLY=7'h09 and CRC16_POLY=16'h1021
  - state encoding localparams (IDLE=0, ACCEPT=1, SHIFT=2, DONE=3)
  - SD_BLOCK_BYTES=512
- Natural sub-module: crc_lfsr_step. It is the combinational single-bit update (crc_in, bit_in -> crc_next), reused by future parallel variants.
- The FSM, shift register and counter stay in crc_stream.

Test Plan:
1. CRC7, stream CMD0 bytes 40 00 00 00 00 with in_last on the 5th byte, in_valid held high. Required: done pulses at cycle 46, crc_out=7'h4A (framed 0x95), crc_ok=0.
2. CRC7, stream CMD8 bytes 48 00 00 01 AA with in_valid toggling 1-0 every cycle. Required: crc_out=7'h43 (framed 0x87); stalls extend latency only, and in_data changes while in_ready=0 do not alter the result.
3. CRC16 (POLY 16'h1021, INIT 0), stream 512 bytes of 0xFF. Required: crc_out=16'h7FA1, one done pulse. Then stream the same 512 bytes followed by 7F A1 (514 words). Required: crc_out=16'h0000, crc_ok=1.
4. Assert start during SHIFT of word 2 of CMD0. Required: ignored, result still 7'h4A. Assert clear during word 3. Required: IDLE next cycle, no done, busy=0. A fresh start then yields 7'h4A.
5. Drop rst_n asynchronously mid-SHIFT, between clock edges. Required: busy, in_ready and done go 0 and crc_out goes to INIT without waiting for a clock edge. After release, a full CMD0 run gives 7'h4A.
6. Single-word message: in_data=8'h00 with in_last=1. Required: done at cycle 10, crc_out=7'h00, crc_ok=1. A start asserted in the DONE cycle is ignored; in_ready stays 0 in the following IDLE cycle.

Source files
------------

// File: rtl/sd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_pkg
// Description : Shared constants for the SD/SPI link CRC engines.
//               CRC generator polynomials (implicit top term omitted), FSM
//               state encoding for crc_stream, and the SD data block size.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sd_pkg;

    // x^7 + x^3 + 1, used on SD command frames
    localparam logic [6:0]  CRC7_POLY  = 7'h09;
    // x^16 + x^12 + x^5 + 1 (CCITT), used on SD data blocks
    localparam logic [15:0] CRC16_POLY = 16'h1021;

    localparam int SD_BLOCK_BYTES = 512;

    // crc_stream FSM encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCEPT = 2'd1;
    localparam state_t ST_SHIFT  = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

endpackage : sd_pkg
`default_nettype wire

// File: rtl/crc_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : crc_stream_if
// Description : Control / word-stream / result bundle for crc_stream.
//               master : message source (drives start, clear, word stream)
//               slave  : CRC engine (drives ready, status and result)
// Ports       : none (signals listed below, grouped by modport)
//               start, clear, in_data[DATA_W], in_valid, in_last  -> engine
//               in_ready, busy, crc_out[CRC_W], crc_ok, done      <- engine
// Revision    : 1.0 - initial release
// ============================================================================
interface crc_stream_if #(
    parameter int DATA_W = 8,
    parameter int CRC_W  = 7
);

    logic              start;
    logic              clear;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              busy;
    logic [CRC_W-1:0]  crc_out;
    logic              crc_ok;
    logic              done;

    modport master (
        output start, clear, in_data, in_valid, in_last,
        input  in_ready, busy, crc_out, crc_ok, done
    );

    modport slave (
        input  start, clear, in_data, in_valid, in_last,
        output in_ready, busy, crc_out, crc_ok, done
    );

endinterface : crc_stream_if
`default_nettype wire

// File: rtl/crc_lfsr_step.sv
`default_nettype none
// ============================================================================
// Module      : crc_lfsr_step
// Description : Combinational single-bit CRC update (Galois form, MSB first).
//               Kept separate so parallel (multi-bit per cycle) variants can
//               chain several instances.
// Ports       : crc_i [CRC_W]  current CRC register
//               bit_i          next message bit
//               crc_o [CRC_W]  updated CRC register
// Revision    : 1.0 - initial release
// ============================================================================
module crc_lfsr_step
    import sd_pkg::*;
#(
    parameter int               CRC_W = 7,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(CRC7_POLY)
) (
    input  wire logic [CRC_W-1:0] crc_i,
    input  wire logic             bit_i,
    output logic      [CRC_W-1:0] crc_o
);

    logic w_fb;

    // Feedback is the bit leaving the register combined with the message bit
    assign w_fb  = crc_i[CRC_W-1] ^ bit_i;
    assign crc_o = {crc_i[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : {CRC_W{1'b0}});

endmodule : crc_lfsr_step
`default_nettype wire

// File: rtl/crc_stream.sv
`default_nettype none
// ============================================================================
// Module      : crc_stream
// Description : Bit-serial streaming CRC engine. Words are accepted one at a
//               time through a ready/valid handshake and shifted MSB first,
//               one bit per clock. done pulses for one cycle once the word
//               flagged in_last has been shifted; crc_ok flags a zero residue
//               (message followed by its own CRC).
// Ports       : clk    system clock, rising edge
//               rst_n  asynchronous active-low reset
//               bus    crc_stream_if.slave (start/clear, word stream, result)
// Revision    : 1.0 - initial release
// ============================================================================
module crc_stream
    import sd_pkg::*;
#(
    parameter int               CRC_W  = 7,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(CRC7_POLY),
    parameter logic [CRC_W-1:0] INIT   = {CRC_W{1'b0}},
    parameter int               DATA_W = 8,
    // Derived; do not override
    parameter int               CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    crc_stream_if.slave bus
);

    state_t            state_q, state_d;
    logic [CRC_W-1:0]  crc_q,   crc_d;
    logic [DATA_W-1:0] sh_q,    sh_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              last_q,  last_d;

    logic [CRC_W-1:0]  w_crc_next;

    crc_lfsr_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_step (
        .crc_i (crc_q),
        .bit_i (sh_q[DATA_W-1]),
        .crc_o (w_crc_next)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. clear wins over everything; start is only looked
    // at in IDLE, so a start while busy or in DONE has no effect.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (bus.start)    state_d = ST_ACCEPT;
                ST_ACCEPT: if (bus.in_valid) state_d = ST_SHIFT;
                ST_SHIFT:  if (cnt_q == '0)  state_d = last_q ? ST_DONE : ST_ACCEPT;
                ST_DONE:                     state_d = ST_IDLE;
                default:                     state_d = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs (state-decoded only, so in_ready has no input path)
    // ------------------------------------------------------------------
    always_comb begin
        bus.in_ready = (state_q == ST_ACCEPT);
        bus.busy     = (state_q != ST_IDLE);
        bus.done     = (state_q == ST_DONE);
        bus.crc_ok   = (state_q == ST_DONE) && (crc_q == '0);
    end

    assign bus.crc_out = crc_q;

    // ------------------------------------------------------------------
    // Datapath: CRC register, shift register, bit counter, last flag
    // ------------------------------------------------------------------
    always_comb begin
        crc_d  = crc_q;
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        last_d = last_q;
        if (bus.clear) begin
            crc_d  = INIT;
            sh_d   = '0;
            cnt_d  = '0;
            last_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // crc_out keeps the previous result until a new start
                    if (bus.start) crc_d = INIT;
                end
                ST_ACCEPT: begin
                    if (bus.in_valid) begin
                        sh_d   = bus.in_data;
                        last_d = bus.in_last;
                        cnt_d  = CNT_W'(DATA_W - 1);
                    end
                end
                ST_SHIFT: begin
                    crc_d = w_crc_next;
                    sh_d  = sh_q << 1;
                    if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q  <= INIT;
            sh_q   <= '0;
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            crc_q  <= crc_d;
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

endmodule : crc_stream
`default_nettype wire

// File: tb/tb_crc_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_crc_stream
// Description : Self-checking bench for crc_stream. A CRC7 instance and a
//               CRC16 instance share clk/rst_n. Expected results are queued
//               when a message is launched and compared when done pulses.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_stream;
    import sd_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    crc_stream_if #(.DATA_W(8), .CRC_W(7))  if7 ();
    crc_stream_if #(.DATA_W(8), .CRC_W(16)) if16 ();

    crc_stream #(
        .CRC_W(7), .POLY(CRC7_POLY), .INIT(7'h00), .DATA_W(8)
    ) u_crc7 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if7)
    );

    crc_stream #(
        .CRC_W(16), .POLY(CRC16_POLY), .INIT(16'h0000), .DATA_W(8)
    ) u_crc16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16)
    );

    typedef struct {
        logic [15:0] crc;
        logic        ok;
        int          lat;   // -1: latency not checked
    } exp_t;

    exp_t q7[$];
    exp_t q16[$];

    int n_checks  = 0;
    int n_errors  = 0;
    int cyc       = 0;
    int t_start7  = 0;
    int t_start16 = 0;
    int n_done7   = 0;
    int n_done16  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference CRC: bitwise, MSB first, zero initial value
    function automatic logic [15:0] crc_model(input logic [7:0] msg[$], input int w,
                                              input logic [15:0] poly);
        logic [15:0] c;
        logic [15:0] mask;
        logic        fb;
        c    = '0;
        mask = 16'((32'd1 << w) - 1);
        foreach (msg[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[w-1] ^ msg[i][b];
                c  = ((c << 1) & mask) ^ (fb ? poly : 16'h0000);
            end
        end
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Result monitors (scoreboard pop side)
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        if (if7.done === 1'b1) begin
            n_done7++;
            if (q7.size() == 0) begin
                check("crc7_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q7.pop_front();
                check("crc7_crc", 32'(if7.crc_out), 32'(e.crc));
                check("crc7_ok",  32'(if7.crc_ok),  32'(e.ok));
                if (e.lat >= 0) check("crc7_latency", 32'(cyc - t_start7), 32'(e.lat));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (if16.done === 1'b1) begin
            n_done16++;
            if (q16.size() == 0) begin
                check("crc16_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q16.pop_front();
                check("crc16_crc", 32'(if16.crc_out), 32'(e.crc));
                check("crc16_ok",  32'(if16.crc_ok),  32'(e.ok));
                if (e.lat >= 0) check("crc16_latency", 32'(cyc - t_start16), 32'(e.lat));
            end
        end
    end

    // ------------------------------------------------------------------
    // CRC7 message driver. toggle=1: in_valid alternates 1/0 and data /
    // last are randomised whenever no handshake can happen.
    // ------------------------------------------------------------------
    task automatic send7(input logic [7:0] msg[$], input bit toggle,
                         input logic [6:0] exp_crc, input logic exp_ok, input int exp_lat);
        int   idx    = 0;
        int   budget = 0;
        int   d0;
        bit   ph     = 1'b1;
        logic v;
        exp_t e;
        e.crc = 16'(exp_crc);
        e.ok  = exp_ok;
        e.lat = exp_lat;
        q7.push_back(e);
        d0 = n_done7;
        step();
        if7.start = 1'b1;
        t_start7  = cyc;
        step();
        if7.start = 1'b0;
        while (idx < msg.size() && budget < 4000) begin
            v  = toggle ? ph : 1'b1;
            ph = ~ph;
            if7.in_valid = v;
            if (v && if7.in_ready) begin
                if7.in_data = msg[idx];
                if7.in_last = (idx == msg.size() - 1);
                idx++;
            end else begin
                if7.in_data = toggle ? 8'($urandom) : msg[idx];
                if7.in_last = toggle ? 1'($urandom) : 1'b0;
            end
            step();
            budget++;
        end
        if7.in_valid = 1'b0;
        if7.in_last  = 1'b0;
        while (n_done7 == d0 && budget < 4000) begin
            step();
            budget++;
        end
        if (n_done7 == d0) check("crc7_done_timeout", 32'd0, 32'd1);
    endtask

    // CRC16 message driver, in_valid held high
    task automatic send16(input logic [7:0] msg[$], input logic [15:0] exp_crc,
                          input logic exp_ok, input int exp_lat);
        int   idx    = 0;
        int   budget = 0;
        int   d0;
        exp_t e;
        e.crc = exp_crc;
        e.ok  = exp_ok;
        e.lat = exp_lat;
        q16.push_back(e);
        d0 = n_done16;
        step();
        if16.start = 1'b1;
        t_start16  = cyc;
        step();
        if16.start = 1'b0;
        while (idx < msg.size() && budget < 20000) begin
            if16.in_valid = 1'b1;
            if16.in_data  = msg[idx];
            if16.in_last  = (idx == msg.size() - 1);
            if (if16.in_ready) idx++;
            step();
            budget++;
        end
        if16.in_valid = 1'b0;
        if16.in_last  = 1'b0;
        while (n_done16 == d0 && budget < 20000) begin
            step();
            budget++;
        end
        if (n_done16 == d0) check("crc16_done_timeout", 32'd0, 32'd1);
    endtask

    // Start a CMD0 run by hand (used where the run is aborted part-way)
    task automatic start_cmd0_manual(output int t0);
        step();
        if7.start = 1'b1;
        t0 = cyc;
        step();
        if7.start    = 1'b0;
        if7.in_valid = 1'b1;
        if7.in_data  = 8'h40;
        if7.in_last  = 1'b0;
        step();
        if7.in_data  = 8'h00;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  cmd0[$]   = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
        logic [7:0]  cmd8[$]   = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA};
        logic [7:0]  single[$] = '{8'h00};
        logic [7:0]  rmsg[$];
        logic [7:0]  blk[$];
        logic [15:0] m;
        int          t0;
        int          d0;

        {if7.start, if7.clear, if7.in_valid, if7.in_last}     = '0;
        {if16.start, if16.clear, if16.in_valid, if16.in_last} = '0;
        if7.in_data  = '0;
        if16.in_data = '0;

        // Reset state
        repeat (3) step();
        check("rst_busy",     32'(if7.busy),     32'd0);
        check("rst_in_ready", 32'(if7.in_ready), 32'd0);
        check("rst_done",     32'(if7.done),     32'd0);
        check("rst_crc_ok",   32'(if7.crc_ok),   32'd0);
        check("rst_crc7",     32'(if7.crc_out),  32'd0);
        check("rst_crc16",    32'(if16.crc_out), 32'd0);
        rst_n = 1'b1;
        step();

        // CMD0, valid held high
        send7(cmd0, 1'b0, 7'h4A, 1'b0, 46);
        // CMD8, valid toggling, junk data while stalled
        send7(cmd8, 1'b1, 7'h43, 1'b0, -1);
        // Random CRC7 message against the reference model
        for (int i = 0; i < 6; i++) rmsg.push_back(8'($urandom));
        m = crc_model(rmsg, 7, 16'(CRC7_POLY));
        send7(rmsg, 1'b1, m[6:0], (m == 16'h0), -1);

        // CRC16 data block of 0xFF, then the block plus its CRC
        for (int i = 0; i < SD_BLOCK_BYTES; i++) blk.push_back(8'hFF);
        send16(blk, 16'h7FA1, 1'b0, 1 + SD_BLOCK_BYTES * 9);
        blk.push_back(8'h7F);
        blk.push_back(8'hA1);
        send16(blk, 16'h0000, 1'b1, 1 + (SD_BLOCK_BYTES + 2) * 9);

        // start during SHIFT of word 2 is ignored
        t0 = cyc + 1;
        fork
            send7(cmd0, 1'b0, 7'h4A, 1'b0, 46);
            begin
                while (cyc != t0 + 13) step();
                if7.start = 1'b1;
                step();
                if7.start = 1'b0;
                check("start_while_busy", 32'(if7.busy), 32'd1);
            end
        join

        // clear during word 3
        start_cmd0_manual(t0);
        while (cyc != t0 + 22) step();
        check("pre_clear_busy", 32'(if7.busy), 32'd1);
        if7.clear = 1'b1;
        d0 = n_done7;
        step();
        if7.clear    = 1'b0;
        if7.in_valid = 1'b0;
        @(negedge clk);
        check("clear_busy",     32'(if7.busy),     32'd0);
        check("clear_in_ready", 32'(if7.in_ready), 32'd0);
        check("clear_done",     32'(if7.done),     32'd0);
        repeat (30) step();
        check("clear_no_done", 32'(n_done7), 32'(d0));
        send7(cmd0, 1'b0, 7'h4A, 1'b0, 46);

        // async reset mid-SHIFT, between clock edges
        start_cmd0_manual(t0);
        while (cyc != t0 + 15) step();
        #2;
        check("pre_rst_busy", 32'(if7.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_busy",     32'(if7.busy),     32'd0);
        check("arst_in_ready", 32'(if7.in_ready), 32'd0);
        check("arst_done",     32'(if7.done),     32'd0);
        check("arst_crc_init", 32'(if7.crc_out),  32'd0);
        if7.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send7(cmd0, 1'b0, 7'h4A, 1'b0, 46);

        // single zero word; start in the DONE cycle is ignored
        t0 = cyc + 1;
        fork
            send7(single, 1'b0, 7'h00, 1'b1, 10);
            begin
                while (cyc != t0 + 10) step();
                if7.start = 1'b1;
                step();
                if7.start = 1'b0;
                @(negedge clk);
                check("post_done_in_ready", 32'(if7.in_ready), 32'd0);
                check("post_done_busy",     32'(if7.busy),     32'd0);
                step();
                @(negedge clk);
                check("post_done_idle", 32'(if7.in_ready), 32'd0);
            end
        join

        repeat (5) step();
        check("crc7_queue_empty",  32'(q7.size()),  32'd0);
        check("crc16_queue_empty", 32'(q16.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_crc_stream
`default_nettype wire
